// File: rtl/instr_decode_seq.sv
// ============================================================================
// Module   : instr_decode_seq
// Purpose  : Pushbutton-driven instruction sequencer. Two raw keys are
//            synchronised and debounced; an execute press latches the
//            instruction switches, decodes them into register-bank addresses
//            and an immediate, waits ALU_LAT cycles and issues a one-cycle
//            write strobe carrying the ALU result. A read press loads the
//            bank read addresses directly from the switches.
// Ports    : clk, rst_n             - clock, async active-low reset
//            i_key_exec_n           - raw execute key (active low)
//            i_key_read_n           - raw register-inspect key (active low)
//            i_sw[15:0]             - instruction word {op, f1, f2, f3}
//            i_alu_result[15:0]     - result returned by the ALU
//            o_opcode[3:0]          - opcode of the latched instruction
//            o_reg_a/b/c[4:0]       - read A, read B, write addresses
//            o_imm[15:0], o_imm_sel - zero-extended immediate and its select
//            o_wr_en, o_wr_data     - register-bank write strobe and data
//            o_busy, o_illegal      - not-idle flag, sticky bad-opcode flag
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_decode_seq #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int ALU_LAT         = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_key_exec_n,
  input  logic        i_key_read_n,
  input  logic [15:0] i_sw,
  input  logic [15:0] i_alu_result,
  output logic [3:0]  o_opcode,
  output logic [4:0]  o_reg_a,
  output logic [4:0]  o_reg_b,
  output logic [4:0]  o_reg_c,
  output logic [15:0] o_imm,
  output logic        o_imm_sel,
  output logic        o_wr_en,
  output logic [15:0] o_wr_data,
  output logic        o_busy,
  output logic        o_illegal
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [3:0]       c_LAT_LAST = 4'(ALU_LAT - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DECODE = 2'd1;
  localparam logic [1:0] S_EXEC   = 2'd2;
  localparam logic [1:0] S_WRITE  = 2'd3;

  // index 0 = execute key, index 1 = read key
  logic [1:0] w_key_n;
  logic [1:0] w_press;

  assign w_key_n = {i_key_read_n, i_key_exec_n};

  for (genvar k = 0; k < 2; k++) begin : g_key
    logic             r_s1;
    logic             r_s2;
    logic             r_db;
    logic [CNT_W-1:0] r_cnt;
    logic             w_done;

    // Counter runs only while the synchronised level differs from the
    // accepted level; any agreeing sample restarts the count.
    assign w_done = (r_s2 != r_db) && (r_cnt == c_CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_s1  <= 1'b1;
        r_s2  <= 1'b1;
        r_db  <= 1'b1;
        r_cnt <= '0;
      end else begin
        r_s1 <= w_key_n[k];
        r_s2 <= r_s1;
        if (r_s2 == r_db) begin
          r_cnt <= '0;
        end else if (w_done) begin
          r_cnt <= '0;
          r_db  <= r_s2;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end
    end

    // Accepted level is about to fall 1->0: one-cycle press event.
    assign w_press[k] = w_done & r_db;
  end

  logic [1:0]  r_state;
  logic [15:0] r_ir;
  logic [3:0]  r_opcode;
  logic [3:0]  r_reg_a;
  logic [3:0]  r_reg_b;
  logic [3:0]  r_reg_c;
  logic [15:0] r_imm;
  logic        r_imm_sel;
  logic [15:0] r_wr_data;
  logic        r_illegal;
  logic [3:0]  r_lat_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_ir      <= '0;
      r_opcode  <= '0;
      r_reg_a   <= '0;
      r_reg_b   <= '0;
      r_reg_c   <= '0;
      r_imm     <= '0;
      r_imm_sel <= 1'b0;
      r_wr_data <= '0;
      r_illegal <= 1'b0;
      r_lat_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // Execute takes priority; a simultaneous read is dropped.
          if (w_press[0]) begin
            r_ir      <= i_sw;
            r_illegal <= 1'b0;
            r_state   <= S_DECODE;
          end else if (w_press[1]) begin
            r_reg_a   <= i_sw[11:8];
            r_reg_b   <= i_sw[7:4];
            r_imm_sel <= 1'b0;
          end
        end
        S_DECODE: begin
          r_opcode  <= r_ir[15:12];
          r_lat_cnt <= '0;
          if (r_ir[15:12] <= 4'd5) begin
            r_reg_c   <= r_ir[11:8];
            r_reg_a   <= r_ir[7:4];
            r_reg_b   <= r_ir[3:0];
            r_imm_sel <= 1'b0;
            r_imm     <= '0;
            r_state   <= S_EXEC;
          end else if (r_ir[15:12] <= 4'd10) begin
            r_reg_c   <= r_ir[11:8];
            r_imm     <= {12'h000, r_ir[7:4]};
            r_reg_b   <= r_ir[3:0];
            r_imm_sel <= 1'b1;
            r_state   <= S_EXEC;
          end else begin
            r_illegal <= 1'b1;
            r_state   <= S_IDLE;
          end
        end
        S_EXEC: begin
          if (r_lat_cnt == c_LAT_LAST) begin
            r_wr_data <= i_alu_result;
            r_state   <= S_WRITE;
          end else begin
            r_lat_cnt <= r_lat_cnt + 4'd1;
          end
        end
        S_WRITE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Strobe and busy are decoded from state so reset clears them at once.
  assign o_wr_en   = (r_state == S_WRITE);
  assign o_busy    = (r_state != S_IDLE);
  assign o_opcode  = r_opcode;
  assign o_reg_a   = {1'b0, r_reg_a};
  assign o_reg_b   = {1'b0, r_reg_b};
  assign o_reg_c   = {1'b0, r_reg_c};
  assign o_imm     = r_imm;
  assign o_imm_sel = r_imm_sel;
  assign o_wr_data = r_wr_data;
  assign o_illegal = r_illegal;

endmodule

`default_nettype wire

// File: tb/tb_instr_decode_seq.sv
// ============================================================================
// Module   : tb_instr_decode_seq
// Purpose  : Directed self-checking bench for instr_decode_seq. u_dut runs
//            with ALU_LAT=1; u_dut_l shares its inputs with ALU_LAT=15 so a
//            second key press can land inside a long EXEC phase.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instr_decode_seq;

  localparam int DB = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        r_key_exec_n = 1'b1;
  logic        r_key_read_n = 1'b1;
  logic [15:0] r_sw = '0;
  logic [15:0] r_alu = '0;

  logic [3:0]  w_opcode,  w_opcode_l;
  logic [4:0]  w_reg_a,   w_reg_a_l;
  logic [4:0]  w_reg_b,   w_reg_b_l;
  logic [4:0]  w_reg_c,   w_reg_c_l;
  logic [15:0] w_imm,     w_imm_l;
  logic        w_imm_sel, w_imm_sel_l;
  logic        w_wr_en,   w_wr_en_l;
  logic [15:0] w_wr_data, w_wr_data_l;
  logic        w_busy,    w_busy_l;
  logic        w_illegal, w_illegal_l;

  int n_checks = 0;
  int n_errors = 0;
  int wr_cnt = 0, start_cnt = 0, wr_cnt_l = 0, start_cnt_l = 0;
  logic busy_q = 1'b0, busy_q_l = 1'b0;

  always #5 clk = ~clk;

  instr_decode_seq #(.DEBOUNCE_CYCLES(DB), .ALU_LAT(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .i_key_exec_n(r_key_exec_n), .i_key_read_n(r_key_read_n),
    .i_sw(r_sw), .i_alu_result(r_alu), .o_opcode(w_opcode), .o_reg_a(w_reg_a),
    .o_reg_b(w_reg_b), .o_reg_c(w_reg_c), .o_imm(w_imm), .o_imm_sel(w_imm_sel),
    .o_wr_en(w_wr_en), .o_wr_data(w_wr_data), .o_busy(w_busy), .o_illegal(w_illegal)
  );

  instr_decode_seq #(.DEBOUNCE_CYCLES(DB), .ALU_LAT(15)) u_dut_l (
    .clk(clk), .rst_n(rst_n), .i_key_exec_n(r_key_exec_n), .i_key_read_n(r_key_read_n),
    .i_sw(r_sw), .i_alu_result(r_alu), .o_opcode(w_opcode_l), .o_reg_a(w_reg_a_l),
    .o_reg_b(w_reg_b_l), .o_reg_c(w_reg_c_l), .o_imm(w_imm_l), .o_imm_sel(w_imm_sel_l),
    .o_wr_en(w_wr_en_l), .o_wr_data(w_wr_data_l), .o_busy(w_busy_l), .o_illegal(w_illegal_l)
  );

  // Count write-strobe cycles and IDLE->busy transitions of both instances.
  always @(negedge clk) begin
    if (w_wr_en)   wr_cnt++;
    if (w_wr_en_l) wr_cnt_l++;
    if (w_busy && !busy_q)     start_cnt++;
    if (w_busy_l && !busy_q_l) start_cnt_l++;
    busy_q   = w_busy;
    busy_q_l = w_busy_l;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Returns at the first falling edge where u_dut reports busy (DECODE).
  task automatic wait_busy(input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (w_busy) begin
        ok = 1'b1;
        break;
      end
    end
    check({tag, "_busy_seen"}, 32'(ok), 32'd1);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // R-type sequence on u_dut from DECODE through return to IDLE.
  task automatic run_rtype(input string tag, input logic [15:0] exp_data);
    wait_busy(tag);
    @(negedge clk);
    check({tag, "_exec_busy"}, 32'(w_busy), 32'd1);
    check({tag, "_exec_wr_en"}, 32'(w_wr_en), 32'd0);
    @(negedge clk);
    check({tag, "_write_wr_en"}, 32'(w_wr_en), 32'd1);
    check({tag, "_wr_data"}, 32'(w_wr_data), 32'(exp_data));
    @(negedge clk);
    check({tag, "_after_wr_en"}, 32'(w_wr_en), 32'd0);
    check({tag, "_after_busy"}, 32'(w_busy), 32'd0);
  endtask

  int base_wr, base_st, base_wr_l, base_st_l;

  initial begin
    // ---------------- reset values
    idle_cycles(3);
    check("rst_opcode", 32'(w_opcode), 32'd0);
    check("rst_reg_c", 32'(w_reg_c), 32'd0);
    check("rst_imm", 32'(w_imm), 32'd0);
    check("rst_flags", 32'({w_imm_sel, w_wr_en, w_busy, w_illegal}), 32'd0);
    check("rst_wr_data", 32'(w_wr_data), 32'd0);
    rst_n = 1'b1;
    idle_cycles(5);

    // ---------------- R-type 0312
    r_sw = 16'h0312; r_alu = 16'h0007;
    base_wr = wr_cnt;
    r_key_exec_n = 1'b0;
    run_rtype("r0312", 16'h0007);
    check("r0312_reg_c", 32'(w_reg_c), 32'd3);
    check("r0312_reg_a", 32'(w_reg_a), 32'd1);
    check("r0312_reg_b", 32'(w_reg_b), 32'd2);
    check("r0312_imm_sel", 32'(w_imm_sel), 32'd0);
    idle_cycles(10);
    r_key_exec_n = 1'b1;
    idle_cycles(10);
    check("r0312_one_pulse", 32'(wr_cnt - base_wr), 32'd1);

    // ---------------- I-type 7A94
    r_sw = 16'h7A94; r_alu = 16'h00A5;
    base_wr = wr_cnt;
    r_key_exec_n = 1'b0;
    run_rtype("i7a94", 16'h00A5);
    check("i7a94_opcode", 32'(w_opcode), 32'd7);
    check("i7a94_reg_c", 32'(w_reg_c), 32'd10);
    check("i7a94_imm", 32'(w_imm), 32'h0009);
    check("i7a94_reg_b", 32'(w_reg_b), 32'd4);
    check("i7a94_imm_sel", 32'(w_imm_sel), 32'd1);
    check("i7a94_reg_a_kept", 32'(w_reg_a), 32'd1);
    r_key_exec_n = 1'b1;
    idle_cycles(10);
    check("i7a94_one_pulse", 32'(wr_cnt - base_wr), 32'd1);

    // ---------------- read key only
    r_sw = 16'h0AB0;
    base_st = start_cnt;
    r_key_read_n = 1'b0;
    idle_cycles(12);
    r_key_read_n = 1'b1;
    idle_cycles(10);
    check("read_reg_a", 32'(w_reg_a), 32'd10);
    check("read_reg_b", 32'(w_reg_b), 32'd11);
    check("read_imm_sel", 32'(w_imm_sel), 32'd0);
    check("read_reg_c_kept", 32'(w_reg_c), 32'd10);
    check("read_no_start", 32'(start_cnt - base_st), 32'd0);

    // ---------------- illegal C123, then a valid instruction clears it
    r_sw = 16'hC123;
    base_wr = wr_cnt;
    r_key_exec_n = 1'b0;
    wait_busy("ill");
    @(negedge clk);
    check("ill_busy", 32'(w_busy), 32'd0);
    check("ill_flag", 32'(w_illegal), 32'd1);
    check("ill_opcode", 32'(w_opcode), 32'hC);
    r_key_exec_n = 1'b1;
    idle_cycles(10);
    check("ill_no_write", 32'(wr_cnt - base_wr), 32'd0);
    check("ill_sticky", 32'(w_illegal), 32'd1);
    idle_cycles(20);
    r_sw = 16'h0312; r_alu = 16'h1234;
    r_key_exec_n = 1'b0;
    run_rtype("clr", 16'h1234);
    check("clr_illegal", 32'(w_illegal), 32'd0);
    r_key_exec_n = 1'b1;
    idle_cycles(30);

    // ---------------- bouncing exec key, then a long hold
    base_wr = wr_cnt; base_st = start_cnt;
    r_sw = 16'h0221;
    r_key_exec_n = 1'b0; idle_cycles(2);
    r_key_exec_n = 1'b1; idle_cycles(1);
    r_key_exec_n = 1'b0; idle_cycles(3);
    r_key_exec_n = 1'b1; idle_cycles(2);
    r_key_exec_n = 1'b0; idle_cycles(1);
    r_key_exec_n = 1'b1; idle_cycles(1);
    r_key_exec_n = 1'b0; idle_cycles(100);
    r_key_exec_n = 1'b1;
    idle_cycles(30);
    check("bounce_starts", 32'(start_cnt - base_st), 32'd1);
    check("bounce_writes", 32'(wr_cnt - base_wr), 32'd1);

    // ---------------- both keys at once; re-press during long EXEC
    r_sw = 16'h0456;
    base_st_l = start_cnt_l; base_wr_l = wr_cnt_l;
    r_key_exec_n = 1'b0; r_key_read_n = 1'b0;
    wait_busy("both");
    check("both_long_busy", 32'(w_busy_l), 32'd1);
    r_key_exec_n = 1'b1; r_key_read_n = 1'b1;
    @(negedge clk);
    check("both_reg_c", 32'(w_reg_c), 32'd4);
    check("both_reg_a", 32'(w_reg_a), 32'd5);
    check("both_reg_b", 32'(w_reg_b), 32'd6);
    idle_cycles(5);
    check("both_long_in_exec", 32'(w_busy_l), 32'd1);
    r_key_exec_n = 1'b0;
    idle_cycles(30);
    r_key_exec_n = 1'b1;
    idle_cycles(30);
    check("both_long_starts", 32'(start_cnt_l - base_st_l), 32'd1);
    check("both_long_writes", 32'(wr_cnt_l - base_wr_l), 32'd1);
    check("both_long_reg_c", 32'(w_reg_c_l), 32'd4);

    // ---------------- reset during EXEC
    r_sw = 16'h0312; r_alu = 16'h0007;
    base_wr = wr_cnt;
    r_key_exec_n = 1'b0;
    wait_busy("rx");
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rx_busy", 32'(w_busy), 32'd0);
    check("rx_wr_en", 32'(w_wr_en), 32'd0);
    check("rx_regs", 32'({w_reg_a, w_reg_b, w_reg_c}), 32'd0);
    check("rx_opcode_imm", 32'({w_opcode, w_imm}), 32'd0);
    check("rx_wr_data", 32'(w_wr_data), 32'd0);
    r_key_exec_n = 1'b1;
    idle_cycles(3);
    rst_n = 1'b1;
    idle_cycles(15);
    check("rx_no_write", 32'(wr_cnt - base_wr), 32'd0);
    check("rx_idle", 32'(w_busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
